// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//   Instruction fetch queue between the I-cache response (fetch) and the
//   decoder. Holds {pc, instruction word} pairs in arrival order and shows
//   the oldest one to the decoder. A flush (branch/jump redirect) drops
//   every buffered entry.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   fetch presents an instruction this cycle
//   in_pc      pc of the presented instruction
//   in_data    presented instruction word
//   in_ready   queue can take a push this cycle (depends on state only)
//   out_valid  head entry is valid
//   out_pc     head entry pc (0 when empty)
//   out_data   head entry instruction word (0 when empty)
//   out_ready  decoder consumes the head this cycle
//   flush      discard all entries; takes priority over push and pop
//   count      number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module inst_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [ADDR_WIDTH-1:0]      in_pc,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rptr_reg;
  logic [PTR_W-1:0] wptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [PTR_W-1:0] rptr_next;
  logic [PTR_W-1:0] wptr_next;
  logic [CNT_W-1:0] cnt_next;

  // Entry storage. Read asynchronously so a pushed entry is visible on the
  // output the cycle after its push edge without an extra read stage.
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic push;
  logic pop;

  // Handshakes. in_ready and out_valid come from registered state only, so
  // out_ready/flush never reach in_ready combinationally.
  assign in_ready  = (cnt_reg != FULL_CNT);
  assign out_valid = (cnt_reg != '0);
  assign push      = in_valid  & in_ready  & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = cnt_reg;

  // Head is forced to zero while empty so stale storage never leaks out.
  assign out_pc   = out_valid ? pc_mem[rptr_reg]   : '0;
  assign out_data = out_valid ? data_mem[rptr_reg] : '0;

  // Pointer and occupancy next-state. Pointers wrap naturally because DEPTH
  // is a power of two.
  always_comb begin
    rptr_next = rptr_reg;
    wptr_next = wptr_reg;
    cnt_next  = cnt_reg;
    if (flush) begin
      rptr_next = '0;
      wptr_next = '0;
      cnt_next  = '0;
    end else begin
      if (push) begin
        wptr_next = wptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rptr_next = rptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_next = cnt_reg + CNT_W'(1);
        2'b01:   cnt_next = cnt_reg - CNT_W'(1);
        default: cnt_next = cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_reg <= '0;
      wptr_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      rptr_reg <= rptr_next;
      wptr_reg <= wptr_next;
      cnt_reg  <= cnt_next;
    end
  end

  // Per-entry write: pc and data of one push always land in the same slot.
  // Storage is intentionally not reset; cnt alone defines what is valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wptr_reg == PTR_W'(gi))) begin
        pc_mem[gi]   <= in_pc;
        data_mem[gi] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one rising edge, then settle 1ns so outputs are sampled
  // away from the edge and new inputs are driven away from it too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dat(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] d);
    in_valid = v;
    in_pc    = pc;
    in_data  = d;
  endtask

  initial begin
    logic [31:0] tpc [3];
    logic [31:0] tdt [3];
    tpc[0] = 32'h0; tpc[1] = 32'h4; tpc[2] = 32'h8;
    tdt[0] = 32'h2408_0001; tdt[1] = 32'h2409_0002; tdt[2] = 32'h240A_0003;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    cyc(); cyc();
    rst = 1'b0;
    check("rst_count",    64'(count),     64'd0);
    check("rst_outvalid", 64'(out_valid), 64'd0);
    check("rst_outpc",    64'(out_pc),    64'd0);
    check("rst_outdata",  64'(out_data),  64'd0);
    check("rst_inready",  64'(in_ready),  64'd1);

    // Three pushes, decoder stalled
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, tpc[i], tdt[i]);
      cyc();
      check("fill_head_valid", 64'(out_valid), 64'd1);
      check("fill_head_pc",    64'(out_pc),    64'h0);
      check("fill_head_data",  64'(out_data),  64'h2408_0001);
    end
    check("fill_count3", 64'(count), 64'd3);

    // Fill to full, then offer 0x10 while full
    drive(1'b1, 32'hC, 32'h240B_0004);
    cyc();
    check("full_count",   64'(count),    64'd4);
    check("full_inready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h10, dat(32'h10));
    cyc();
    check("full_hold_count", 64'(count),  64'd4);
    check("full_hold_head",  64'(out_pc), 64'h0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("full_pop_head",    64'(out_pc),   64'h4);
    check("full_pop_inready", 64'(in_ready), 64'd1);
    check("full_pop_count",   64'(count),    64'd3);
    cyc();
    check("refill_count", 64'(count), 64'd4);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc",   64'(out_pc),   64'(32'h4 + 32'(4 * i)));
      check("drain_data", 64'(out_data),
            64'((i == 0) ? 32'h2409_0002 : (i == 1) ? 32'h240A_0003 :
                (i == 2) ? 32'h240B_0004 : dat(32'h10)));
      cyc();
    end
    check("drain_empty", 64'(out_valid), 64'd0);

    // Steady stream across pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), dat(32'h100 + 32'(4 * i)));
      cyc();
      check("stream_pc",    64'(out_pc),   64'(32'h100 + 32'(4 * i)));
      check("stream_data",  64'(out_data), 64'(dat(32'h100 + 32'(4 * i))));
      check("stream_count", 64'(count),    64'd1);
    end
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    check("stream_drained", 64'(count), 64'd0);

    // Flush with 3 queued and a push offered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h180 + 32'(4 * i), dat(32'h180 + 32'(4 * i)));
      cyc();
    end
    check("preflush_count", 64'(count), 64'd3);
    drive(1'b1, 32'h200, dat(32'h200));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_count",    64'(count),     64'd0);
    check("flush_outvalid", 64'(out_valid), 64'd0);
    check("flush_outpc",    64'(out_pc),    64'd0);
    check("flush_outdata",  64'(out_data),  64'd0);
    drive(1'b1, 32'h300, dat(32'h300));
    cyc();
    check("postflush_pc",    64'(out_pc), 64'h300);
    check("postflush_count", 64'(count),  64'd1);

    // Reset mid-operation with 2 queued
    drive(1'b1, 32'h304, dat(32'h304));
    cyc();
    check("prerst_count", 64'(count), 64'd2);
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h308, dat(32'h308));
    cyc();
    rst = 1'b0;
    check("midrst_count",    64'(count),     64'd0);
    check("midrst_outvalid", 64'(out_valid), 64'd0);
    check("midrst_inready",  64'(in_ready),  64'd1);

    // Empty queue: push with out_ready high is push only
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    drive(1'b1, 32'h40, dat(32'h40));
    out_ready = 1'b1;
    #1;
    check("empty_push_outvalid", 64'(out_valid), 64'd0);
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b0;
    check("empty_push_next_valid", 64'(out_valid), 64'd1);
    check("empty_push_next_pc",    64'(out_pc),    64'h40);
    check("empty_push_next_count", 64'(count),     64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
